// File: rtl/auto_move_generator.sv
// auto_move_generator: automated player-2 opponent for tic-tac-toe.
// Snapshots the board on request and scans win, block, centre, corners, edges.
`default_nettype none

module auto_move_generator #(
    parameter logic [1:0] SELF_MARK = 2'b10,
    parameter logic [1:0] OPP_MARK  = 2'b01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] move_position,
    output logic       move_valid,
    output logic       no_move,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCAN_WIN   = 3'd1,
        ST_SCAN_BLOCK = 3'd2,
        ST_CENTRE     = 3'd3,
        ST_CORNER     = 3'd4,
        ST_EDGE       = 3'd5,
        ST_RESULT     = 3'd6,
        ST_NO_MOVE    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_snap [0:8];
    logic [2:0] r_line;
    logic [2:0] w_line_nxt;
    logic [1:0] r_sub;
    logic [1:0] w_sub_nxt;
    logic [3:0] r_move_pos;
    logic [3:0] w_move_pos_nxt;
    logic [3:0] w_ia;
    logic [3:0] w_ib;
    logic [3:0] w_ic;
    logic [1:0] w_ca;
    logic [1:0] w_cb;
    logic [1:0] w_cc;
    logic [3:0] w_line_empty;
    logic [3:0] w_corner_code;
    logic [3:0] w_edge_code;
    logic       w_self_hit;
    logic       w_opp_hit;

    // Exactly two cells carry the mark and the third is empty; a 2'b11 cell never matches.
    function automatic logic line_hit(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] m);
        return ((a == m) && (b == m) && (c == 2'b00)) ||
               ((a == m) && (b == 2'b00) && (c == m)) ||
               ((a == 2'b00) && (b == m) && (c == m));
    endfunction

    always_comb begin
        w_ia = 4'd0;
        w_ib = 4'd1;
        w_ic = 4'd2;
        case (r_line)
            3'd0: begin w_ia = 4'd0; w_ib = 4'd1; w_ic = 4'd2; end
            3'd1: begin w_ia = 4'd3; w_ib = 4'd4; w_ic = 4'd5; end
            3'd2: begin w_ia = 4'd6; w_ib = 4'd7; w_ic = 4'd8; end
            3'd3: begin w_ia = 4'd0; w_ib = 4'd3; w_ic = 4'd6; end
            3'd4: begin w_ia = 4'd1; w_ib = 4'd4; w_ic = 4'd7; end
            3'd5: begin w_ia = 4'd2; w_ib = 4'd5; w_ic = 4'd8; end
            3'd6: begin w_ia = 4'd0; w_ib = 4'd4; w_ic = 4'd8; end
            default: begin w_ia = 4'd2; w_ib = 4'd4; w_ic = 4'd6; end
        endcase
    end

    assign w_ca         = r_snap[w_ia];
    assign w_cb         = r_snap[w_ib];
    assign w_cc         = r_snap[w_ic];
    assign w_self_hit   = line_hit(w_ca, w_cb, w_cc, SELF_MARK);
    assign w_opp_hit    = line_hit(w_ca, w_cb, w_cc, OPP_MARK);
    assign w_line_empty = (w_ca == 2'b00) ? w_ia : ((w_cb == 2'b00) ? w_ib : w_ic);

    always_comb begin
        w_corner_code = 4'd0;
        w_edge_code   = 4'd1;
        case (r_sub)
            2'd0: begin w_corner_code = 4'd0; w_edge_code = 4'd1; end
            2'd1: begin w_corner_code = 4'd2; w_edge_code = 4'd3; end
            2'd2: begin w_corner_code = 4'd6; w_edge_code = 4'd5; end
            default: begin w_corner_code = 4'd8; w_edge_code = 4'd7; end
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_line_nxt     = 3'd0;
        w_sub_nxt      = 2'd0;
        w_move_pos_nxt = r_move_pos;
        case (r_state)
            ST_IDLE: begin
                if (req) w_state_nxt = ST_SCAN_WIN;
            end
            ST_SCAN_WIN: begin
                if (w_self_hit) begin
                    w_state_nxt    = ST_RESULT;
                    w_move_pos_nxt = w_line_empty;
                end else begin
                    w_line_nxt = r_line + 3'd1;
                    if (r_line == 3'd7) w_state_nxt = ST_SCAN_BLOCK;
                end
            end
            ST_SCAN_BLOCK: begin
                if (w_opp_hit) begin
                    w_state_nxt    = ST_RESULT;
                    w_move_pos_nxt = w_line_empty;
                end else begin
                    w_line_nxt = r_line + 3'd1;
                    if (r_line == 3'd7) w_state_nxt = ST_CENTRE;
                end
            end
            ST_CENTRE: begin
                if (r_snap[4] == 2'b00) begin
                    w_state_nxt    = ST_RESULT;
                    w_move_pos_nxt = 4'd4;
                end else begin
                    w_state_nxt = ST_CORNER;
                end
            end
            ST_CORNER: begin
                if (r_snap[w_corner_code] == 2'b00) begin
                    w_state_nxt    = ST_RESULT;
                    w_move_pos_nxt = w_corner_code;
                end else begin
                    w_sub_nxt = r_sub + 2'd1;
                    if (r_sub == 2'd3) w_state_nxt = ST_EDGE;
                end
            end
            ST_EDGE: begin
                if (r_snap[w_edge_code] == 2'b00) begin
                    w_state_nxt    = ST_RESULT;
                    w_move_pos_nxt = w_edge_code;
                end else begin
                    w_sub_nxt = r_sub + 2'd1;
                    if (r_sub == 2'd3) begin
                        w_state_nxt    = ST_NO_MOVE;
                        w_move_pos_nxt = 4'd15;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_line     <= 3'd0;
            r_sub      <= 2'd0;
            r_move_pos <= 4'd15;
        end else begin
            r_state    <= w_state_nxt;
            r_line     <= w_line_nxt;
            r_sub      <= w_sub_nxt;
            r_move_pos <= w_move_pos_nxt;
        end
    end

    // The scan reads only this copy, so board changes mid-scan have no effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) r_snap[i] <= 2'b00;
        end else if (r_state == ST_IDLE && req) begin
            r_snap[0] <= pos1;
            r_snap[1] <= pos2;
            r_snap[2] <= pos3;
            r_snap[3] <= pos4;
            r_snap[4] <= pos5;
            r_snap[5] <= pos6;
            r_snap[6] <= pos7;
            r_snap[7] <= pos8;
            r_snap[8] <= pos9;
        end
    end

    assign move_position = r_move_pos;
    assign move_valid    = (r_state == ST_RESULT);
    assign no_move       = (r_state == ST_NO_MOVE);
    assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_auto_move_generator.sv
// tb_auto_move_generator: directed scoreboard bench for auto_move_generator.
`default_nettype none

module tb_auto_move_generator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req   = 1'b0;
    logic [1:0] b [0:8];
    logic [3:0] move_position;
    logic       move_valid;
    logic       no_move;
    logic       busy;

    typedef struct {
        int         lat;
        logic [3:0] pos;
        logic       nm;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    auto_move_generator dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .pos1          (b[0]),
        .pos2          (b[1]),
        .pos3          (b[2]),
        .pos4          (b[3]),
        .pos5          (b[4]),
        .pos6          (b[5]),
        .pos7          (b[6]),
        .pos8          (b[7]),
        .pos9          (b[8]),
        .move_position (move_position),
        .move_valid    (move_valid),
        .no_move       (no_move),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Board word: pos1 in bits [17:16] down to pos9 in bits [1:0].
    task automatic set_board(input logic [17:0] v);
        for (int i = 0; i < 9; i++) b[i] = v[17-2*i -: 2];
    endtask

    task automatic issue(input int l, input logic [3:0] p, input logic m);
        sb.push_back('{lat: l, pos: p, nm: m});
        req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
    endtask

    // act_kind: 0 none, 1 change board inputs, 2 raise req for one cycle.
    task automatic await_result(input string tag, input int act_cycle, input int act_kind);
        exp_t e;
        int   n;
        bit   done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (move_valid === 1'b1 || no_move === 1'b1) begin
                done = 1'b1;
                chk({tag, "_sb_depth"}, sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_latency"}, n, e.lat);
                    chk({tag, "_no_move"}, {31'd0, no_move}, {31'd0, e.nm});
                    chk({tag, "_valid"}, {31'd0, move_valid}, {31'd0, ~e.nm});
                    chk({tag, "_position"}, {28'd0, move_position}, {28'd0, e.pos});
                end
            end
            chk({tag, "_busy"}, {31'd0, busy}, 1);
            if (n == act_cycle && act_kind == 1) set_board(18'b00_00_00_00_00_00_10_10_00);
            if (n == act_cycle && act_kind == 2) req = 1'b1;
            if (n == act_cycle + 1 && act_kind == 2) req = 1'b0;
        end
        chk({tag, "_done"}, {31'd0, done}, 1);
        req = 1'b0;
        @(negedge clock);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
        chk({tag, "_idle_valid"}, {31'd0, move_valid}, 0);
        chk({tag, "_idle_no_move"}, {31'd0, no_move}, 0);
        if (e.lat > 0) chk({tag, "_hold"}, {28'd0, move_position}, {28'd0, e.pos});
    endtask

    initial begin
        set_board(18'd0);
        repeat (2) @(negedge clock);
        chk("rst_pos", {28'd0, move_position}, 15);
        chk("rst_valid", {31'd0, move_valid}, 0);
        chk("rst_no_move", {31'd0, no_move}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        @(negedge clock);

        set_board(18'd0);
        issue(18, 4'd4, 1'b0);
        await_result("empty_centre", 0, 0);

        set_board(18'b10_10_00_00_00_00_00_00_00);
        issue(2, 4'd2, 1'b0);
        await_result("win_line0", 0, 0);

        set_board(18'b00_00_10_00_10_00_00_00_00);
        issue(9, 4'd6, 1'b0);
        await_result("win_line7", 0, 0);

        set_board(18'b00_00_01_00_01_00_00_00_00);
        issue(17, 4'd6, 1'b0);
        await_result("block_line7", 0, 0);

        set_board(18'b10_00_00_00_01_00_00_00_00);
        issue(20, 4'd2, 1'b0);
        await_result("corner_pos3", 0, 0);

        set_board(18'b10_11_01_00_11_00_01_00_10);
        issue(24, 4'd3, 1'b0);
        await_result("edge_pos4", 0, 0);

        set_board(18'b10_10_11_00_00_00_00_00_00);
        issue(18, 4'd4, 1'b0);
        await_result("line_with_11", 0, 0);

        set_board(18'b10_01_10_01_01_10_01_10_11);
        issue(26, 4'd15, 1'b1);
        await_result("full_board", 0, 0);

        set_board(18'b00_00_01_00_01_00_00_00_00);
        issue(17, 4'd6, 1'b0);
        await_result("snapshot_hold", 3, 1);

        set_board(18'd0);
        issue(18, 4'd4, 1'b0);
        await_result("req_ignored", 5, 2);

        // Abort a scan with reset: outputs return to idle values at once.
        set_board(18'd0);
        req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_busy_before", {31'd0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("abort_pos", {28'd0, move_position}, 15);
        chk("abort_valid", {31'd0, move_valid}, 0);
        chk("abort_no_move", {31'd0, no_move}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_no_pulse", {31'd0, move_valid | no_move | busy}, 0);

        set_board(18'b10_10_00_00_00_00_00_00_00);
        issue(2, 4'd2, 1'b0);
        await_result("restart_after_reset", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
